// File: rtl/mlp_hidden_sched.sv
// mlp_hidden_sched: job sequencer for a single mlp_hidden_layer core.
//
// Takes one input vector from a valid/ready stream, hands it to the core on
// core_bus_in with a one-cycle core_start pulse, waits for core_done, then
// captures the flattened hidden outputs and offers them on a valid/ready
// result stream. Only one job is in flight at a time. A watchdog abandons a
// job after TIMEOUT_CYC wait cycles and raises a sticky err_timeout flag.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       input vector handshake, in_data = vector
//   core_bus_in, core_start vector and start pulse to the core
//   core_hidden, core_done  core hidden outputs and completion level
//   out_valid/out_ready     result handshake, out_data = captured result
//   busy                    high whenever the scheduler is not idle
//   err_timeout, err_clear  sticky watchdog flag and its clear
//   jobs_done               completed-job count, wraps at 16 bits
//
// Build option: define MLP_SCHED_RELU_EN to clamp each negative ACC_W slice
// of core_hidden to zero as it is captured. Timing is identical either way.
module mlp_hidden_sched #(
    parameter int IN_DIM      = 4,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int HIDDEN_SIZE = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W*IN_DIM-1:0]      in_data,
    output logic [DATA_W*IN_DIM-1:0]      core_bus_in,
    output logic                          core_start,
    input  logic [ACC_W*HIDDEN_SIZE-1:0]  core_hidden,
    input  logic                          core_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W*HIDDEN_SIZE-1:0]  out_data,
    output logic                          busy,
    output logic                          err_timeout,
    input  logic                          err_clear,
    output logic [15:0]                   jobs_done
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [TMR_W-1:0]               r_timer;
    logic                           r_armed;
    logic                           w_complete;
    logic                           w_timeout;
    logic                           w_accept;
    logic [ACC_W*HIDDEN_SIZE-1:0]   w_capture;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    // Completion needs done to have been seen low during this job first, so a
    // done level left over from the previous job cannot end this one early.
    assign w_complete = (r_state == S_WAIT) && r_armed && core_done;
    assign w_timeout  = (r_state == S_WAIT) && !w_complete && (r_timer == TMR_LAST);

    always_comb begin
        w_capture = core_hidden;
`ifdef MLP_SCHED_RELU_EN
        for (int h = 0; h < HIDDEN_SIZE; h++) begin
            if (core_hidden[h*ACC_W + ACC_W - 1]) begin
                w_capture[h*ACC_W +: ACC_W] = '0;
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_complete)     w_state_nxt = S_OUT;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Combinational state decodes
    always_comb begin
        in_ready = (r_state == S_IDLE);
        busy     = (r_state != S_IDLE);
    end

    // Registered outputs and job bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_bus_in <= '0;
            core_start  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_timeout <= 1'b0;
            jobs_done   <= '0;
            r_timer     <= '0;
            r_armed     <= 1'b0;
        end else begin
            // Registered on accept so the pulse lands in the START cycle.
            core_start <= w_accept;
            if (w_accept) begin
                core_bus_in <= in_data;
            end

            if (r_state == S_START) begin
                r_timer <= '0;
                r_armed <= 1'b0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + 1'b1;
                if (!core_done) begin
                    r_armed <= 1'b1;
                end
            end

            if (w_complete) begin
                out_data  <= w_capture;
                out_valid <= 1'b1;
                jobs_done <= jobs_done + 16'd1;
            end else if ((r_state == S_OUT) && out_ready) begin
                out_valid <= 1'b0;
            end

            // A timeout in the same cycle as a clear leaves the flag set.
            if (w_timeout) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mlp_hidden_sched.sv
// Self-checking bench for mlp_hidden_sched (TIMEOUT_CYC = 16) with a
// behavioural core whose done timing is set per job.
module tb_mlp_hidden_sched;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] core_bus_in;
    logic        core_start;
    logic [31:0] core_hidden;
    logic        core_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
    logic        err_timeout;
    logic        err_clear = 1'b0;
    logic [15:0] jobs_done;

    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;

    always #5 clk = ~clk;

    mlp_hidden_sched #(
        .IN_DIM(4), .DATA_W(8), .ACC_W(16), .HIDDEN_SIZE(2), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_bus_in(core_bus_in), .core_start(core_start),
        .core_hidden(core_hidden), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear),
        .jobs_done(jobs_done)
    );

    // Behavioural core: m_cnt = cycles since the start pulse. done is high for
    // c < m_lo (stale level from the previous job) and from c >= m_dly on,
    // unless m_never is set.
    int          m_cnt = 1000;
    bit          m_started = 1'b0;
    int          m_lo = 1;
    int          m_dly = 5;
    bit          m_never = 1'b0;
    logic [31:0] m_hidden = 32'hFFF0_0012;

    assign core_hidden = m_hidden;
    assign core_done   = m_started && ((m_cnt < m_lo) || (!m_never && (m_cnt >= m_dly)));

    always @(posedge clk) begin
        if (core_start) begin
            m_cnt     <= 1;
            m_started <= 1'b1;
        end else if (m_cnt < 1000) begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Reference: cycles after accept at which out_valid appears (positive) or
    // at which the scheduler is back in IDLE after a timeout (negative).
    function automatic int exp_t(input int lo, input int dly, input bit never);
        bit armed = 1'b0;
        bit d;
        for (int c = 1; c <= TMO; c++) begin
            d = (c < lo) || (!never && (c >= dly));
            if (armed && d) return c + 2;
            if (!d) armed = 1'b1;
        end
        return -(TMO + 2);
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] h);
        logic [31:0] r = h;
`ifdef MLP_SCHED_RELU_EN
        for (int i = 0; i < 2; i++) if (h[i*16 + 15]) r[i*16 +: 16] = 16'h0;
`endif
        return r;
    endfunction

    // Drives one job from a negedge and observes it; no comparisons here.
    task automatic drive_job(input logic [31:0] d, output int lat, output int starts,
                             output int start_t, output logic [31:0] bus,
                             output logic [31:0] od);
        int w = 0;
        lat = 0; starts = 0; start_t = -1; bus = 'x; od = 'x;
        while (!in_ready && w < 8) begin @(negedge clk); w++; end
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            if (t == 1) bus = core_bus_in;
            if (core_start) begin starts++; if (start_t < 0) start_t = t; end
            if (out_valid) begin lat = t; od = out_data; break; end
            if (in_ready) begin lat = -t; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({in_ready, busy, core_start, out_valid, err_timeout} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctl: got %b want 10000", {in_ready, busy, core_start, out_valid, err_timeout}); end
        checks++; if ({out_data, core_bus_in, jobs_done} !== 80'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {out_data, core_bus_in, jobs_done}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, starts, st; logic [31:0] bus, od;
        m_lo = 1; m_dly = 5; m_never = 1'b0; m_hidden = 32'hFFF0_0012;
        drive_job(32'h0403_0201, lat, starts, st, bus, od);
        exp_jobs++;
        checks++; if (st !== 1 || starts !== 1) begin
            errors++; $display("FAIL basic_start: got t=%0d n=%0d want t=1 n=1", st, starts); end
        checks++; if (bus !== 32'h0403_0201) begin
            errors++; $display("FAIL basic_bus: got %h want 04030201", bus); end
        checks++; if (lat !== exp_t(1, 5, 0)) begin
            errors++; $display("FAIL basic_lat: got %0d want %0d", lat, exp_t(1, 5, 0)); end
        checks++; if (od !== relu(32'hFFF0_0012)) begin
            errors++; $display("FAIL basic_data: got %h want %h", od, relu(32'hFFF0_0012)); end
        checks++; if (jobs_done !== 16'(exp_jobs)) begin
            errors++; $display("FAIL basic_jobs: got %0d want %0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_stall();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== relu(32'hFFF0_0012) || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hs_ready: got %b want 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat, starts, st; logic [31:0] bus, od;
        // done is still high from the previous job and stays high for the
        // first three wait cycles.
        m_lo = 4; m_dly = 6; m_hidden = 32'h7FFF_8000;
        drive_job(32'hA5A5_0F0F, lat, starts, st, bus, od);
        exp_jobs++;
        checks++; if (lat !== exp_t(4, 6, 0)) begin
            errors++; $display("FAIL b2b_lat: got %0d want %0d", lat, exp_t(4, 6, 0)); end
        checks++; if (od !== relu(32'h7FFF_8000)) begin
            errors++; $display("FAIL b2b_data: got %h want %h", od, relu(32'h7FFF_8000)); end
        checks++; if (jobs_done !== 16'(exp_jobs)) begin
            errors++; $display("FAIL b2b_jobs: got %0d want %0d", jobs_done, exp_jobs); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int lat, starts, st; logic [31:0] bus, od;
        m_lo = 1; m_never = 1'b1;
        drive_job(32'h1122_3344, lat, starts, st, bus, od);
        checks++; if (lat !== -(TMO + 2) || out_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_lat: got %0d valid=%b want %0d 0", lat, out_valid, -(TMO + 2)); end
        checks++; if (err_timeout !== 1'b1 || jobs_done !== 16'(exp_jobs)) begin
            errors++; $display("FAIL tmo_flag: got err=%b jobs=%0d want 1 %0d", err_timeout, jobs_done, exp_jobs); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: got %b want 0", err_timeout); end
        // Done arriving on the last wait cycle beats the watchdog.
        m_never = 1'b0; m_dly = TMO;
        drive_job(32'h5566_7788, lat, starts, st, bus, od);
        exp_jobs++;
        checks++; if (lat !== exp_t(1, TMO, 0) || err_timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_edge: got %0d err=%b want %0d 0", lat, err_timeout, exp_t(1, TMO, 0)); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        // Clear held through a timeout: the set wins.
        m_never = 1'b1; err_clear = 1'b1;
        drive_job(32'h99AA_BBCC, lat, starts, st, bus, od);
        checks++; if (lat !== -(TMO + 2) || err_timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_setwins: got %0d err=%b want %0d 1", lat, err_timeout, -(TMO + 2)); end
        err_clear = 1'b0; @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        m_never = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, starts, st; logic [31:0] bus, od;
        m_lo = 1; m_dly = 5; m_hidden = 32'h0042_FFFF;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset_n = 1'b0; #1;
        exp_jobs = 0;
        checks++; if ({in_ready, busy, core_start, out_valid, err_timeout} !== 5'b10000) begin
            errors++; $display("FAIL mid_ctl: got %b want 10000", {in_ready, busy, core_start, out_valid, err_timeout}); end
        checks++; if ({out_data, core_bus_in, jobs_done} !== 80'h0) begin
            errors++; $display("FAIL mid_data: got %h want 0", {out_data, core_bus_in, jobs_done}); end
        @(negedge clk); reset_n = 1'b1; @(negedge clk);
        drive_job(32'h0102_0304, lat, starts, st, bus, od);
        exp_jobs++;
        checks++; if (lat !== exp_t(1, 5, 0) || od !== relu(32'h0042_FFFF) || jobs_done !== 16'(exp_jobs)) begin
            errors++; $display("FAIL mid_rerun: got lat=%0d data=%h jobs=%0d want %0d %h %0d",
                               lat, od, jobs_done, exp_t(1, 5, 0), relu(32'h0042_FFFF), exp_jobs); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat, starts, st, e; logic [31:0] bus, od, d;
        for (int n = 0; n < 25; n++) begin
            d = $urandom; m_hidden = $urandom;
            m_lo = $urandom_range(1, 4); m_dly = $urandom_range(2, 20);
            m_never = ($urandom_range(0, 5) == 0);
            e = exp_t(m_lo, m_dly, m_never);
            drive_job(d, lat, starts, st, bus, od);
            checks++; if (lat !== e || starts !== 1 || bus !== d) begin
                errors++; $display("FAIL rnd%0d_job: got lat=%0d n=%0d bus=%h want %0d 1 %h", n, lat, starts, bus, e, d); end
            if (e > 0) begin
                exp_jobs++;
                checks++; if (od !== relu(m_hidden) || jobs_done !== 16'(exp_jobs)) begin
                    errors++; $display("FAIL rnd%0d_out: got %h jobs=%0d want %h %0d", n, od, jobs_done, relu(m_hidden), exp_jobs); end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
                checks++; if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_drop: got %b want 0", n, out_valid); end
            end else begin
                checks++; if (err_timeout !== 1'b1 || jobs_done !== 16'(exp_jobs)) begin
                    errors++; $display("FAIL rnd%0d_tmo: got err=%b jobs=%0d want 1 %0d", n, err_timeout, jobs_done, exp_jobs); end
                err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
